dac_update_scheduler: RTL
=========================

# dac_update_scheduler

Round-robin scheduler that shares the single SPI DAC master (cs/scl/mosi/ldac frame engine) between NUM_CH channel requesters. It snapshots pending channel requests into a batch, issues one 24-bit write frame per channel through a start/done handshake, then pulses LDAC so all channels of the batch update simultaneously. It sits between the per-channel waveform/control logic and spi_master, and owns the DAC's ldac line.

## Interface
- NUM_CH, 4, number of requesting channels (2..8); channel index is the DAC address nibble
- DATA_W, 16, DAC code width; frame width FRAME_W = DATA_W + 8
- CMD_WR, 4'h1, command nibble "write input register" (used with LDAC_SYNC_EN)
- CMD_WRUPD, 4'h3, command nibble "write and update" (used without LDAC_SYNC_EN)
- LDAC_W, 2, ldac_o low-pulse width in sys_clk_i cycles (>=1)
- TIMEOUT, 1024, max cycles in WAIT for spi_done_i before abort
- sys_clk_i  in  1  system clock, all logic on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- ch_req_i  in  NUM_CH  level request per channel, held until acked
- ch_data_i  in  NUM_CH*DATA_W  channel codes, channel k at [k*DATA_W +: DATA_W]
- ch_ack_o  out  NUM_CH  one-cycle pulse: channel k's code captured
- spi_start_o  out  1  one-cycle start pulse to spi_master
- spi_frame_o  out  FRAME_W  {cmd[3:0], addr[3:0], data}, stable from start until done
- spi_busy_i  in  1  spi_master frame in progress
- spi_done_i  in  1  one-cycle pulse, frame shifted out
- ldac_o  out  1  active-low DAC load strobe, idle high
- busy_o  out  1  high whenever state != IDLE
- err_o  out  1  sticky timeout flag
- err_clr_i  in  1  synchronous clear of err_o

## Operation
- States: IDLE, SEL, START, WAIT, LDAC.
- IDLE: if ch_req_i != 0, pending <= ch_req_i, go SEL. Requests arriving later are served in the next batch.
- SEL: grant g = first set bit of pending searching from (rr_ptr+1) mod NUM_CH upward with wrap; latch spi_frame_o <= {cmd, g[3:0], ch_data_i[g]}; ch_ack_o[g] = 1 this cycle; pending[g] <= 0; rr_ptr <= g; go START.
- START: if spi_busy_i = 0, spi_start_o = 1 for this cycle, clear timeout counter, go WAIT; else stay, start low.
- WAIT: count cycles. On spi_done_i: if pending != 0 go SEL, else go LDAC (macro on) or IDLE (macro off). If count reaches TIMEOUT before done: err_o <= 1, pending <= 0, go IDLE, no LDAC pulse.
- LDAC: ldac_o = 0 for exactly LDAC_W cycles, then IDLE.
- err_clr_i clears err_o; if timeout occurs in the same cycle, set wins.
- spi_done_i outside WAIT is ignored.

## Timing
- Reset values: ch_ack_o=0, spi_start_o=0, spi_frame_o=0, ldac_o=1, busy_o=0, err_o=0, rr_ptr=NUM_CH-1 (so channel 0 wins first), pending=0, state IDLE.
- All outputs registered. Request sampled at edge N: ack high in cycle N+1 (SEL), spi_start_o high in cycle N+2 if spi_busy_i low.
- done sampled at edge M: next ack at M+1, or ldac_o low from M+1 for LDAC_W cycles.
- Gap between done and next start: 2 cycles.
- Batch of K channels: K acks, K starts, one LDAC pulse, in rr order.
- Reset mid-batch: all outputs return to reset values immediately (async); pending lost, no LDAC pulse.

## Configuration
- LDAC_SYNC_EN defined: cmd = CMD_WR, LDAC state used, one ldac_o pulse per completed batch.
- LDAC_SYNC_EN undefined: cmd = CMD_WRUPD, LDAC state absent, ldac_o held 1 always, last done goes straight to IDLE; each channel updates on its own frame.

## Test plan
- Reset: assert sys_rst_n=0 mid-WAIT -> ldac_o=1, busy_o=0, start/ack 0; after release ch_req_i=4'b0001 -> first frame addr 0.
- Single request ch2 code 16'hABCD, macro on -> ack[2] pulse, spi_frame_o=24'h12ABCD, one start, after done ldac_o low 2 cycles.
- ch_req_i=4'b1111 at once -> acks in order 0,1,2,3, four starts, exactly one LDAC pulse after 4th done.
- Fairness: rr_ptr=1, requests {0,3} -> order 3 then 0; ch1 raised mid-batch -> served in following batch only.
- spi_busy_i held 1 for 10 cycles in START -> spi_start_o stays 0, then single pulse when busy drops.
- No done for TIMEOUT cycles -> err_o=1, return to IDLE, no ldac pulse; err_clr_i -> err_o=0; macro off build -> ldac_o constant 1, cmd 4'h3.

Source files
------------

// File: rtl/dac_update_scheduler.sv
// dac_update_scheduler
// Round-robin arbiter that shares one SPI DAC frame engine between NUM_CH
// channel requesters. Pending requests are snapshotted into a batch. The block
// issues one {cmd, addr, data} frame per channel through a start/done
// handshake, and can optionally pulse LDAC once per completed batch.
//
// Build option: define LDAC_SYNC_EN to write input registers (CMD_WR) and
// load the whole batch with one ldac_o low pulse. When it is undefined, each
// frame uses CMD_WRUPD and ldac_o stays high.
//
// Ports:
//   sys_clk_i, sys_rst_n   clock, async active-low reset
//   ch_req_i / ch_data_i   level requests and per-channel codes
//   ch_ack_o               one-cycle capture pulse per channel
//   spi_start_o/_frame_o   frame handshake towards spi_master
//   spi_busy_i/_done_i     spi_master status
//   ldac_o                 active-low DAC load strobe
//   busy_o, err_o          scheduler active, sticky timeout flag
//   err_clr_i              synchronous clear of err_o
module dac_update_scheduler #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 16,
    parameter logic [3:0]  CMD_WR    = 4'h1,
    parameter logic [3:0]  CMD_WRUPD = 4'h3,
    parameter int unsigned LDAC_W    = 2,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                     sys_clk_i,
    input  logic                     sys_rst_n,
    input  logic [NUM_CH-1:0]        ch_req_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    output logic [NUM_CH-1:0]        ch_ack_o,
    output logic                     spi_start_o,
    output logic [DATA_W+7:0]        spi_frame_o,
    input  logic                     spi_busy_i,
    input  logic                     spi_done_i,
    output logic                     ldac_o,
    output logic                     busy_o,
    output logic                     err_o,
    input  logic                     err_clr_i
);

`ifdef LDAC_SYNC_EN
    localparam bit LdacSyncEn = 1'b1;
`else
    localparam bit LdacSyncEn = 1'b0;
`endif

    localparam int unsigned FRAME_W = DATA_W + 8;
    localparam int unsigned PTR_W   = $clog2(NUM_CH);
    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned LCNT_W  = $clog2(LDAC_W + 1);
    localparam logic [3:0]  Cmd     = LdacSyncEn ? CMD_WR : CMD_WRUPD;

    typedef enum logic [2:0] {StIdle, StSel, StStart, StWait, StLdac} state_e;

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [PTR_W-1:0]    rr_q, rr_d;
    logic [PTR_W-1:0]    grant_q, grant_d;
    logic [NUM_CH-1:0]   ack_q, ack_d;
    logic                start_q, start_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
    logic                ldac_q, ldac_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    // Round-robin search, starting one past the last grant.
    logic [NUM_CH-1:0]   search_src;
    logic [PTR_W-1:0]    grant_nxt;
    logic [PTR_W-1:0]    search_ptr;
    int unsigned         search_idx;
    logic                found;

    always_comb begin
        // In IDLE the batch is being formed from the live requests.
        search_src = (state_q == StIdle) ? ch_req_i : pending_q;
        grant_nxt  = rr_q;
        search_ptr = '0;
        search_idx = 0;
        found      = 1'b0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            search_idx = (32'(rr_q) + i) % NUM_CH;
            search_ptr = PTR_W'(search_idx);
            if (!found && search_src[search_ptr]) begin
                grant_nxt = search_ptr;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        ack_d     = '0;
        start_d   = 1'b0;
        frame_d   = frame_q;
        cnt_d     = cnt_q;
        lcnt_d    = lcnt_q;
        err_d     = err_q;
        if (err_clr_i) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (|ch_req_i) begin
                    pending_d        = ch_req_i;
                    grant_d          = grant_nxt;
                    ack_d[grant_nxt] = 1'b1;
                    state_d          = StSel;
                end
            end
            StSel: begin
                frame_d            = {Cmd, 4'(grant_q), ch_data_i[32'(grant_q)*DATA_W +: DATA_W]};
                pending_d[grant_q] = 1'b0;
                rr_d               = grant_q;
                start_d            = !spi_busy_i;
                state_d            = StStart;
            end
            StStart: begin
                // start_q high means the pulse is on the output this cycle.
                if (start_q) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    start_d = !spi_busy_i;
                end
            end
            StWait: begin
                if (spi_done_i) begin
                    if (|pending_q) begin
                        grant_d          = grant_nxt;
                        ack_d[grant_nxt] = 1'b1;
                        state_d          = StSel;
                    end else if (LdacSyncEn) begin
                        lcnt_d  = '0;
                        state_d = StLdac;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    pending_d = '0;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLdac: begin
                if (lcnt_q == LCNT_W'(LDAC_W - 1)) begin
                    state_d = StIdle;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
        ldac_d = (state_d != StLdac);
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            rr_q      <= PTR_W'(NUM_CH - 1);
            grant_q   <= '0;
            ack_q     <= '0;
            start_q   <= 1'b0;
            frame_q   <= '0;
            cnt_q     <= '0;
            lcnt_q    <= '0;
            ldac_q    <= 1'b1;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            start_q   <= start_d;
            frame_q   <= frame_d;
            cnt_q     <= cnt_d;
            lcnt_q    <= lcnt_d;
            ldac_q    <= ldac_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign ch_ack_o    = ack_q;
    assign spi_start_o = start_q;
    assign spi_frame_o = frame_q;
    assign ldac_o      = ldac_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule
